// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: PC, stage enables, bubbles, redirect.
// Define PERF_CNT_EN to build the saturating stall counters; otherwise they read 0.
module pipeline_sequencer #(
  parameter int BR_TIMEOUT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_use,
  input  logic             branch_ID,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             br_err,
  output logic [CNT_W-1:0] lu_stalls,
  output logic [CNT_W-1:0] br_stalls,
  output logic [CNT_W-1:0] mem_stalls
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int BW = $clog2(BR_TIMEOUT + 1);
  localparam logic [BW-1:0] BR_LAST = BW'(BR_TIMEOUT - 1);

  state_t        state, state_nx;
  state_t        ret_q, ret_nx;
  state_t        eff;
  logic [BW-1:0] br_cnt, br_cnt_nx;
  logic          br_err_nx;
  logic          freeze;
  logic          lu_hit, br_hit, mem_hit;

  logic pc_en_c, pc_redirect_c;
  logic ifid_en_c, ifid_flush_c;
  logic idex_en_c, idex_bubble_c;
  logic exmem_en_c, memwb_en_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      ret_q  <= RUN;
      br_cnt <= '0;
      br_err <= 1'b0;
    end else begin
      state  <= state_nx;
      ret_q  <= ret_nx;
      br_cnt <= br_cnt_nx;
      br_err <= br_err_nx;
    end
  end

  // In MEM_WAIT the saved state governs the ack cycle.
  assign eff = (state == MEM_WAIT) ? ret_q : state;

  assign freeze = (state == MEM_WAIT) ? ~dmem_ack
                                      : (dmem_req & ~dmem_ack);

  always_comb begin
    pc_en_c       = 1'b1;
    pc_redirect_c = 1'b0;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_en_c     = 1'b1;
    idex_bubble_c = 1'b0;
    exmem_en_c    = 1'b1;
    memwb_en_c    = 1'b1;
    state_nx      = state;
    ret_nx        = ret_q;
    br_cnt_nx     = br_cnt;
    br_err_nx     = br_err;
    lu_hit        = 1'b0;
    br_hit        = 1'b0;
    mem_hit       = 1'b0;

    if (freeze) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
      state_nx   = MEM_WAIT;
      ret_nx     = eff;
      mem_hit    = 1'b1;
    end else begin
      state_nx = eff;
      case (eff)
        BR_WAIT: begin
          br_hit        = 1'b1;
          pc_en_c       = 1'b0;
          ifid_en_c     = 1'b0;
          idex_bubble_c = 1'b1;
          br_cnt_nx     = br_cnt + 1'b1;
          if (br_valid) begin
            pc_en_c       = 1'b1;
            pc_redirect_c = br_taken;
            ifid_flush_c  = 1'b1;
            state_nx      = RUN;
          end else if (br_cnt == BR_LAST) begin
            br_err_nx = 1'b1;
            pc_en_c   = 1'b1;
            state_nx  = RUN;
          end
        end
        default: begin
          if (branch_ID) begin
            pc_en_c      = 1'b0;
            ifid_flush_c = 1'b1;
            br_cnt_nx    = '0;
            state_nx     = BR_WAIT;
          end else if (load_use) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
            lu_hit        = 1'b1;
          end
        end
      endcase
    end
  end

  // Hold every control low for the whole reset assertion.
  assign pc_en       = reset_n & pc_en_c;
  assign pc_redirect = reset_n & pc_redirect_c;
  assign ifid_en     = reset_n & ifid_en_c;
  assign ifid_flush  = reset_n & ifid_flush_c;
  assign idex_en     = reset_n & idex_en_c;
  assign idex_bubble = reset_n & idex_bubble_c;
  assign exmem_en    = reset_n & exmem_en_c;
  assign memwb_en    = reset_n & memwb_en_c;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] lu_q, br_q, mem_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_q  <= '0;
      br_q  <= '0;
      mem_q <= '0;
    end else begin
      if (lu_hit && lu_q != '1)
        lu_q <= lu_q + 1'b1;
      if (br_hit && br_q != '1)
        br_q <= br_q + 1'b1;
      if (mem_hit && mem_q != '1)
        mem_q <= mem_q + 1'b1;
    end
  end

  assign lu_stalls  = lu_q;
  assign br_stalls  = br_q;
  assign mem_stalls = mem_q;
`else
  logic hits_unused;
  assign hits_unused = lu_hit ^ br_hit ^ mem_hit;
  assign lu_stalls   = '0;
  assign br_stalls   = '0;
  assign mem_stalls  = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: stalls, flushes, timeouts, memory freeze.
// Counter expectations scale with PERF_CNT_EN.
module tb_pipeline_sequencer;

  localparam int PERF =
`ifdef PERF_CNT_EN
    1;
`else
    0;
`endif

  // ctl = {pc_en, pc_redirect, ifid_en, ifid_flush,
  //        idex_en, idex_bubble, exmem_en, memwb_en}
  localparam logic [7:0] IDLE  = 8'b1010_1011;
  localparam logic [7:0] FRZ   = 8'b0000_0000;
  localparam logic [7:0] LU    = 8'b0000_1111;
  localparam logic [7:0] BID   = 8'b0011_1011;
  localparam logic [7:0] BRW   = 8'b0000_1111;
  localparam logic [7:0] RES_T = 8'b1101_1111;
  localparam logic [7:0] RES_N = 8'b1001_1111;
  localparam logic [7:0] TOUT  = 8'b1000_1111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic load_use = 1'b0, branch_ID = 1'b0;
  logic br_valid = 1'b0, br_taken = 1'b0;
  logic dmem_req = 1'b0, dmem_ack = 1'b0;
  logic pc_en, pc_redirect, ifid_en, ifid_flush;
  logic idex_en, idex_bubble, exmem_en, memwb_en;
  logic br_err;
  logic [15:0] lu_stalls, br_stalls, mem_stalls;
  logic [7:0] ctl;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.BR_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .load_use(load_use), .branch_ID(branch_ID),
    .br_valid(br_valid), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .pc_redirect(pc_redirect),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .br_err(br_err),
    .lu_stalls(lu_stalls), .br_stalls(br_stalls),
    .mem_stalls(mem_stalls)
  );

  assign ctl = {pc_en, pc_redirect, ifid_en, ifid_flush,
                idex_en, idex_bubble, exmem_en, memwb_en};

  // inputs: {load_use, branch_ID, br_valid, br_taken, dmem_req, dmem_ack}
  task automatic apply(input logic [5:0] v);
    @(negedge clk);
    {load_use, branch_ID, br_valid, br_taken, dmem_req, dmem_ack} = v;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    {load_use, branch_ID, br_valid, br_taken, dmem_req, dmem_ack} = '0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (ctl !== FRZ) begin fails++; $display("FAIL rst_ctl: got %b exp %b", ctl, FRZ); end
    checks++; if (br_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", br_err); end
    checks++; if ({lu_stalls, br_stalls, mem_stalls} !== 48'd0) begin fails++; $display("FAIL rst_cnt: got %h exp 0", {lu_stalls, br_stalls, mem_stalls}); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL rst_rel: got %b exp %b", ctl, IDLE); end
  endtask

  task automatic test_reset_mid_br();
    do_reset();
    apply(6'b010000);
    checks++; if (ctl !== BID) begin fails++; $display("FAIL mrst_bid: got %b exp %b", ctl, BID); end
    apply(6'b000000);
    checks++; if (ctl !== BRW) begin fails++; $display("FAIL mrst_brw: got %b exp %b", ctl, BRW); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (ctl !== FRZ) begin fails++; $display("FAIL mrst_async: got %b exp %b", ctl, FRZ); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL mrst_rel: got %b exp %b", ctl, IDLE); end
    apply(6'b000000);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL mrst_run: got %b exp %b", ctl, IDLE); end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(6'b100000);
    checks++; if (ctl !== LU) begin fails++; $display("FAIL lu_ctl: got %b exp %b", ctl, LU); end
    apply(6'b000000);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL lu_after: got %b exp %b", ctl, IDLE); end
    checks++; if (lu_stalls !== 16'(PERF)) begin fails++; $display("FAIL lu_cnt: got %0d exp %0d", lu_stalls, PERF); end
  endtask

  task automatic test_branch_taken();
    do_reset();
    apply(6'b010000);
    checks++; if (ctl !== BID) begin fails++; $display("FAIL bt_c0: got %b exp %b", ctl, BID); end
    apply(6'b000000);
    checks++; if (ctl !== BRW) begin fails++; $display("FAIL bt_c1: got %b exp %b", ctl, BRW); end
    apply(6'b001100);
    checks++; if (ctl !== RES_T) begin fails++; $display("FAIL bt_res: got %b exp %b", ctl, RES_T); end
    apply(6'b000000);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL bt_run: got %b exp %b", ctl, IDLE); end
    checks++; if (br_stalls !== 16'(2 * PERF)) begin fails++; $display("FAIL bt_cnt: got %0d exp %0d", br_stalls, 2 * PERF); end
    checks++; if (br_err !== 1'b0) begin fails++; $display("FAIL bt_err: got %b exp 0", br_err); end
  endtask

  task automatic test_branch_not_taken();
    do_reset();
    apply(6'b010000);
    checks++; if (ctl !== BID) begin fails++; $display("FAIL bn_c0: got %b exp %b", ctl, BID); end
    apply(6'b001000);
    checks++; if (ctl !== RES_N) begin fails++; $display("FAIL bn_res: got %b exp %b", ctl, RES_N); end
    apply(6'b001100);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL bn_ignore: got %b exp %b", ctl, IDLE); end
    apply(6'b000000);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL bn_run: got %b exp %b", ctl, IDLE); end
  endtask

  task automatic test_timeout();
    do_reset();
    apply(6'b010000);
    for (int i = 0; i < 3; i++) begin
      apply(6'b000000);
      checks++; if (ctl !== BRW) begin fails++; $display("FAIL to_wait%0d: got %b exp %b", i, ctl, BRW); end
    end
    apply(6'b000000);
    checks++; if (ctl !== TOUT) begin fails++; $display("FAIL to_fire: got %b exp %b", ctl, TOUT); end
    checks++; if (br_err !== 1'b0) begin fails++; $display("FAIL to_early: got %b exp 0", br_err); end
    apply(6'b000000);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL to_run: got %b exp %b", ctl, IDLE); end
    checks++; if (br_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b exp 1", br_err); end
    checks++; if (br_stalls !== 16'(4 * PERF)) begin fails++; $display("FAIL to_cnt: got %0d exp %0d", br_stalls, 4 * PERF); end
    apply(6'b010000);
    apply(6'b001100);
    apply(6'b000000);
    checks++; if (br_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b exp 1", br_err); end
  endtask

  task automatic test_mem_in_br();
    do_reset();
    apply(6'b010000);
    apply(6'b000000);
    checks++; if (ctl !== BRW) begin fails++; $display("FAIL mb_brw: got %b exp %b", ctl, BRW); end
    for (int i = 0; i < 3; i++) begin
      apply(6'b000010);
      checks++; if (ctl !== FRZ) begin fails++; $display("FAIL mb_frz%0d: got %b exp %b", i, ctl, FRZ); end
    end
    apply(6'b000011);
    checks++; if (ctl !== BRW) begin fails++; $display("FAIL mb_ack: got %b exp %b", ctl, BRW); end
    apply(6'b000000);
    checks++; if (ctl !== BRW) begin fails++; $display("FAIL mb_hold: got %b exp %b", ctl, BRW); end
    apply(6'b000000);
    checks++; if (ctl !== TOUT) begin fails++; $display("FAIL mb_tout: got %b exp %b", ctl, TOUT); end
    apply(6'b000000);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL mb_run: got %b exp %b", ctl, IDLE); end
    checks++; if (mem_stalls !== 16'(3 * PERF)) begin fails++; $display("FAIL mb_mcnt: got %0d exp %0d", mem_stalls, 3 * PERF); end
    checks++; if (br_stalls !== 16'(4 * PERF)) begin fails++; $display("FAIL mb_bcnt: got %0d exp %0d", br_stalls, 4 * PERF); end
  endtask

  task automatic test_mem_priority();
    do_reset();
    apply(6'b110010);
    checks++; if (ctl !== FRZ) begin fails++; $display("FAIL mp_frz: got %b exp %b", ctl, FRZ); end
    apply(6'b110011);
    checks++; if (ctl !== BID) begin fails++; $display("FAIL mp_ack: got %b exp %b", ctl, BID); end
    apply(6'b001000);
    checks++; if (ctl !== RES_N) begin fails++; $display("FAIL mp_res: got %b exp %b", ctl, RES_N); end
    apply(6'b000000);
    checks++; if (mem_stalls !== 16'(PERF)) begin fails++; $display("FAIL mp_cnt: got %0d exp %0d", mem_stalls, PERF); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    apply(6'b100000);
    checks++; if (ctl !== LU) begin fails++; $display("FAIL bb_lu0: got %b exp %b", ctl, LU); end
    apply(6'b100000);
    checks++; if (ctl !== LU) begin fails++; $display("FAIL bb_lu1: got %b exp %b", ctl, LU); end
    apply(6'b000011);
    checks++; if (ctl !== IDLE) begin fails++; $display("FAIL bb_fastmem: got %b exp %b", ctl, IDLE); end
    checks++; if (lu_stalls !== 16'(2 * PERF)) begin fails++; $display("FAIL bb_cnt: got %0d exp %0d", lu_stalls, 2 * PERF); end
    checks++; if (mem_stalls !== 16'd0) begin fails++; $display("FAIL bb_mcnt: got %0d exp 0", mem_stalls); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_br();
    test_load_use();
    test_branch_taken();
    test_branch_not_taken();
    test_timeout();
    test_mem_in_br();
    test_mem_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
